ray_column_renderer: RTL and testbench

- Parametrised next generation of the DDA-to-framebuffer column flattener.
- Pops one column descriptor per DDA-out FIFO handshake and emits SCREEN_HEIGHT pixel/address pairs to the frame buffer.
- Adds per-map-value wall palette, separate ceiling/floor colours, Y-side shading, line-height clamping, output valid/ready backpressure and out-of-range column rejection.

---
 rtl/ray_column_renderer.sv | 133 +++++++++++++
 tb/tb_ray_column_renderer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_column_renderer.sv
// Column flattener: takes one DDA column descriptor and streams SCREEN_HEIGHT
// pixel/address pairs to the frame buffer under valid/ready flow control.
module ray_column_renderer #(
  parameter int          PIXEL_WIDTH   = 16,
  parameter int          ADDR_WIDTH    = 16,
  parameter int          SCREEN_WIDTH  = 320,
  parameter int          SCREEN_HEIGHT = 180,
  parameter logic [15:0] CEILING_COLOR = 16'hFFFF,
  parameter logic [15:0] FLOOR_COLOR   = 16'h8410,
  parameter bit          SHADE_EN      = 1'b1
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic                   dda_fifo_tvalid_in,
  input  logic [37:0]            dda_fifo_tdata_in,
  input  logic                   dda_fifo_tlast_in,
  output logic                   transformer_tready_out,
  output logic [ADDR_WIDTH-1:0]  ray_address_out,
  output logic [PIXEL_WIDTH-1:0] ray_pixel_out,
  output logic                   ray_last_pixel_out,
  output logic                   ray_valid_out,
  input  logic                   ray_ready_in,
  output logic                   col_error_out
);

  localparam logic [7:0] HEIGHT8 = 8'(SCREEN_HEIGHT);
  localparam logic [8:0] HEIGHT9 = 9'(SCREEN_HEIGHT);
  localparam logic [8:0] MID9    = 9'(SCREEN_HEIGHT / 2);
  localparam logic [9:0] WIDTH10 = 10'(SCREEN_WIDTH);

  typedef enum logic {IDLE, RENDER} state_t;

  state_t      state;
  logic [7:0]  vcount;
  logic [8:0]  hcount_q;
  logic [7:0]  line_height_q;
  logic        y_side_q;
  logic [3:0]  map_q;
  logic [15:0] wallx_unused_q;
  logic        tlast_q;
  logic        out_row_last_q;

  logic [8:0]  half, draw_start, draw_end, end_sum, row9;
  logic [15:0] wall_raw, wall_col, pix_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic        row_last;

  assign transformer_tready_out = (state == IDLE);

  // Empty map cells collapse the wall band to the horizon so only ceiling/floor draw.
  always_comb begin
    half       = (map_q == 4'd0) ? 9'd0 : {2'b00, line_height_q[7:1]};
    draw_start = (half >= MID9) ? 9'd0 : MID9 - half;
    end_sum    = MID9 + half;
    draw_end   = (end_sum > HEIGHT9) ? HEIGHT9 : end_sum;
  end

  always_comb begin
    case (map_q)
      4'd1:    wall_raw = 16'hF800;
      4'd2:    wall_raw = 16'h07E0;
      4'd3:    wall_raw = 16'h001F;
      default: wall_raw = 16'hFFFF;
    endcase
    // Halve each RGB565 channel on its own so no bit leaks between fields.
    if (SHADE_EN && y_side_q)
      wall_col = {1'b0, wall_raw[15:12], 1'b0, wall_raw[10:6], 1'b0, wall_raw[4:1]};
    else
      wall_col = wall_raw;
    row9 = {1'b0, vcount};
    if (row9 < draw_start)      pix_next = CEILING_COLOR;
    else if (row9 >= draw_end)  pix_next = FLOOR_COLOR;
    else                        pix_next = wall_col;
  end

  assign addr_next = ADDR_WIDTH'(32'(hcount_q) + 32'(vcount) * 32'(SCREEN_WIDTH));
  assign row_last  = (vcount == HEIGHT8 - 8'd1);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state              <= IDLE;
      vcount             <= 8'd0;
      hcount_q           <= 9'd0;
      line_height_q      <= 8'd0;
      y_side_q           <= 1'b0;
      map_q              <= 4'd0;
      wallx_unused_q     <= 16'd0;
      tlast_q            <= 1'b0;
      out_row_last_q     <= 1'b0;
      ray_valid_out      <= 1'b0;
      ray_last_pixel_out <= 1'b0;
      ray_address_out    <= '0;
      ray_pixel_out      <= '0;
      col_error_out      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dda_fifo_tvalid_in) begin
            hcount_q       <= dda_fifo_tdata_in[37:29];
            line_height_q  <= dda_fifo_tdata_in[28:21];
            y_side_q       <= dda_fifo_tdata_in[20];
            map_q          <= dda_fifo_tdata_in[19:16];
            wallx_unused_q <= dda_fifo_tdata_in[15:0];
            tlast_q        <= dda_fifo_tlast_in;
            if ({1'b0, dda_fifo_tdata_in[37:29]} >= WIDTH10) begin
              col_error_out <= 1'b1;
            end else begin
              vcount <= 8'd0;
              state  <= RENDER;
            end
          end
        end
        RENDER: begin
          if (ray_valid_out && ray_ready_in && out_row_last_q) begin
            ray_valid_out      <= 1'b0;
            ray_last_pixel_out <= 1'b0;
            out_row_last_q     <= 1'b0;
            state              <= IDLE;
          end else if ((!ray_valid_out || ray_ready_in) && (vcount < HEIGHT8)) begin
            ray_pixel_out      <= pix_next;
            ray_address_out    <= addr_next;
            ray_last_pixel_out <= tlast_q && row_last;
            out_row_last_q     <= row_last;
            ray_valid_out      <= 1'b1;
            vcount             <= vcount + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_column_renderer.sv
// Self-checking bench for ray_column_renderer: directed scenarios plus random
// descriptors and random backpressure against a row-by-row colour model.
module tb_ray_column_renderer;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        dda_fifo_tvalid_in = 1'b0;
  logic [37:0] dda_fifo_tdata_in = '0;
  logic        dda_fifo_tlast_in = 1'b0;
  logic        transformer_tready_out;
  logic [15:0] ray_address_out;
  logic [15:0] ray_pixel_out;
  logic        ray_last_pixel_out;
  logic        ray_valid_out;
  logic        ray_ready_in = 1'b1;
  logic        col_error_out;

  ray_column_renderer dut (
    .pixel_clk_in(pixel_clk_in), .rst_in(rst_in),
    .dda_fifo_tvalid_in(dda_fifo_tvalid_in), .dda_fifo_tdata_in(dda_fifo_tdata_in),
    .dda_fifo_tlast_in(dda_fifo_tlast_in), .transformer_tready_out(transformer_tready_out),
    .ray_address_out(ray_address_out), .ray_pixel_out(ray_pixel_out),
    .ray_last_pixel_out(ray_last_pixel_out), .ray_valid_out(ray_valid_out),
    .ray_ready_in(ray_ready_in), .col_error_out(col_error_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  int cyc = 0;
  always @(posedge pixel_clk_in) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int accept_edge, first_valid_cyc, last_hs_edge, stall_viol, bad_row;
  logic tready_first;
  logic [15:0] obs_addr[$];
  logic [15:0] obs_pix[$];
  logic        obs_last[$];

  // Reference: each row's colour follows directly from the wall band limits.
  function automatic logic [15:0] model_pix(input int lh, input int wt, input int md, input int row);
    int half, ds, de, p, r, g, b;
    half = (md == 0) ? 0 : lh / 2;
    ds = 90 - half; if (ds < 0) ds = 0;
    de = 90 + half; if (de > 180) de = 180;
    if (row < ds) return 16'hFFFF;
    if (row >= de) return 16'h8410;
    p = (md == 1) ? 'hF800 : (md == 2) ? 'h07E0 : (md == 3) ? 'h001F : 'hFFFF;
    if (wt != 0) begin
      r = p / 2048; g = (p / 32) % 64; b = p % 32;
      p = (r / 2) * 2048 + (g / 2) * 32 + (b / 2);
    end
    return p[15:0];
  endfunction

  function automatic int col_mism(input int hc, input int lh, input int wt, input int md, input int tl);
    int bad;
    int ea;
    bad = 0; bad_row = -1;
    if (obs_addr.size() != 180) return 999;
    for (int row = 0; row < 180; row++) begin
      ea = (hc + row * 320) % 65536;
      if (obs_addr[row] !== ea[15:0] || obs_pix[row] !== model_pix(lh, wt, md, row) ||
          obs_last[row] !== ((tl != 0) && row == 179)) begin
        bad++;
        if (bad_row < 0) bad_row = row;
      end
    end
    return bad;
  endfunction

  task automatic send_desc(input int hc, input int lh, input int wt, input int md, input int tl);
    int n;
    n = 0;
    dda_fifo_tvalid_in = 1'b1;
    dda_fifo_tdata_in  = {9'(hc), 8'(lh), 1'(wt), 4'(md), 16'($urandom)};
    dda_fifo_tlast_in  = 1'(tl);
    while (!transformer_tready_out && n < 1000) begin @(negedge pixel_clk_in); n++; end
    checks++;
    if (n >= 1000) begin errors++; $display("FAIL accept_timeout tready got 0 exp 1"); end
    accept_edge = cyc + 1;
    @(negedge pixel_clk_in);
    dda_fifo_tvalid_in = 1'b0;
  endtask

  // mode 0: ready high, 1: toggle from first valid cycle, 2: random ready
  task automatic collect(input int mode, input int max_pix);
    int n, t;
    logic r, pv, pl, seen;
    logic [15:0] pa, pp;
    obs_addr.delete(); obs_pix.delete(); obs_last.delete();
    n = 0; t = 0; pv = 0; pl = 0; pa = 0; pp = 0; seen = 0;
    stall_viol = 0; first_valid_cyc = -1; last_hs_edge = -1;
    tready_first = transformer_tready_out;
    while (obs_addr.size() < max_pix && n < 3000) begin
      if (ray_valid_out && !seen) begin seen = 1; first_valid_cyc = cyc; end
      case (mode)
        0:       r = 1'b1;
        1:       r = seen ? (t % 2 == 0) : 1'b1;
        default: r = ($urandom_range(0, 2) != 0);
      endcase
      if (seen) t++;
      ray_ready_in = r;
      if (pv && (!ray_valid_out || ray_address_out !== pa || ray_pixel_out !== pp ||
                 ray_last_pixel_out !== pl)) stall_viol++;
      pv = ray_valid_out && !r; pa = ray_address_out; pp = ray_pixel_out; pl = ray_last_pixel_out;
      if (ray_valid_out && r) begin
        obs_addr.push_back(ray_address_out);
        obs_pix.push_back(ray_pixel_out);
        obs_last.push_back(ray_last_pixel_out);
        last_hs_edge = cyc + 1;
      end
      @(negedge pixel_clk_in); n++;
    end
    ray_ready_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) @(negedge pixel_clk_in);
    checks++; if (transformer_tready_out !== 1'b1) begin errors++; $display("FAIL reset_tready got %b exp 1", transformer_tready_out); end
    checks++; if (ray_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ray_valid_out); end
    checks++; if (col_error_out !== 1'b0) begin errors++; $display("FAIL reset_col_error got %b exp 0", col_error_out); end
    checks++; if ({ray_address_out, ray_pixel_out, ray_last_pixel_out} !== 33'd0) begin
      errors++; $display("FAIL reset_outputs got addr %h pix %h last %b exp 0", ray_address_out, ray_pixel_out, ray_last_pixel_out); end
    rst_in = 1'b0;
    repeat (3) @(negedge pixel_clk_in);
    checks++; if (ray_valid_out !== 1'b0 || transformer_tready_out !== 1'b1) begin
      errors++; $display("FAIL idle_quiet got valid %b tready %b exp 0 1", ray_valid_out, transformer_tready_out); end
  endtask

  task automatic test_basic();
    int m;
    send_desc(5, 60, 0, 1, 0);
    checks++; if (tready_first !== 1'b0 && transformer_tready_out !== 1'b0) begin
      errors++; $display("FAIL basic_busy tready got 1 exp 0"); end
    collect(0, 180);
    m = col_mism(5, 60, 0, 1, 0);
    checks++; if (m !== 0) begin errors++; $display("FAIL basic_column got %0d bad rows (first %0d) exp 0", m, bad_row); end
    checks++; if (tready_first !== 1'b0) begin errors++; $display("FAIL basic_tready_after_accept got %b exp 0", tready_first); end
    checks++; if (first_valid_cyc - accept_edge !== 1) begin errors++; $display("FAIL basic_first_latency got %0d exp 1", first_valid_cyc - accept_edge); end
    checks++; if (last_hs_edge - accept_edge !== 181) begin errors++; $display("FAIL basic_column_period got %0d exp 181", last_hs_edge - accept_edge); end
    checks++; if (transformer_tready_out !== 1'b1 || ray_valid_out !== 1'b0) begin
      errors++; $display("FAIL basic_return_idle got tready %b valid %b exp 1 0", transformer_tready_out, ray_valid_out); end
    if (obs_addr.size() == 180) begin
      checks++; if (obs_pix[59] !== 16'hFFFF || obs_pix[60] !== 16'hF800 || obs_pix[119] !== 16'hF800 || obs_pix[120] !== 16'h8410) begin
        errors++; $display("FAIL basic_band_edges got %h %h %h %h exp FFFF F800 F800 8410", obs_pix[59], obs_pix[60], obs_pix[119], obs_pix[120]); end
      checks++; if (obs_addr[1] !== 16'd325 || obs_addr[179] !== 16'd57285) begin
        errors++; $display("FAIL basic_addr got %0d %0d exp 325 57285", obs_addr[1], obs_addr[179]); end
    end
  endtask

  task automatic test_shade_clamp();
    int m;
    send_desc(319, 250, 1, 2, 1);
    collect(0, 180);
    m = col_mism(319, 250, 1, 2, 1);
    checks++; if (m !== 0) begin errors++; $display("FAIL shade_clamp got %0d bad rows (first %0d) exp 0", m, bad_row); end
    if (obs_addr.size() == 180) begin
      checks++; if (obs_pix[0] !== 16'h03E0 || obs_pix[179] !== 16'h03E0) begin
        errors++; $display("FAIL shade_colour got %h %h exp 03E0", obs_pix[0], obs_pix[179]); end
      checks++; if (obs_addr[179] !== 16'd57599 || obs_last[179] !== 1'b1 || obs_last[178] !== 1'b0) begin
        errors++; $display("FAIL shade_last got addr %0d last %b/%b exp 57599 1/0", obs_addr[179], obs_last[179], obs_last[178]); end
    end
  endtask

  task automatic test_backpressure();
    int m;
    send_desc(5, 60, 0, 1, 0);
    collect(1, 180);
    m = col_mism(5, 60, 0, 1, 0);
    checks++; if (m !== 0) begin errors++; $display("FAIL bp_column got %0d bad rows (first %0d) exp 0", m, bad_row); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes exp 0", stall_viol); end
    checks++; if (last_hs_edge - first_valid_cyc !== 359) begin errors++; $display("FAIL bp_cycles got %0d exp 359", last_hs_edge - first_valid_cyc); end
  endtask

  task automatic test_invalid();
    int m, first_acc;
    send_desc(320, 100, 0, 1, 1);
    first_acc = accept_edge;
    checks++; if (col_error_out !== 1'b1 || ray_valid_out !== 1'b0 || transformer_tready_out !== 1'b1) begin
      errors++; $display("FAIL invalid_reject got err %b valid %b tready %b exp 1 0 1", col_error_out, ray_valid_out, transformer_tready_out); end
    send_desc(10, 100, 0, 3, 1);
    checks++; if (accept_edge - first_acc !== 1) begin errors++; $display("FAIL invalid_next_accept got %0d exp 1", accept_edge - first_acc); end
    collect(2, 180);
    m = col_mism(10, 100, 0, 3, 1);
    checks++; if (m !== 0) begin errors++; $display("FAIL invalid_then_valid got %0d bad rows (first %0d) exp 0", m, bad_row); end
    checks++; if (col_error_out !== 1'b1 || stall_viol !== 0) begin
      errors++; $display("FAIL invalid_sticky got err %b stalls %0d exp 1 0", col_error_out, stall_viol); end
  endtask

  task automatic test_reset_mid();
    int m;
    send_desc(7, 80, 1, 4, 0);
    collect(0, 50);
    rst_in = 1'b1;
    @(negedge pixel_clk_in);
    checks++; if (ray_valid_out !== 1'b0 || transformer_tready_out !== 1'b1 || col_error_out !== 1'b0) begin
      errors++; $display("FAIL reset_mid got valid %b tready %b err %b exp 0 1 0", ray_valid_out, transformer_tready_out, col_error_out); end
    rst_in = 1'b0;
    @(negedge pixel_clk_in);
    send_desc(8, 40, 0, 1, 1);
    collect(0, 180);
    m = col_mism(8, 40, 0, 1, 1);
    checks++; if (m !== 0) begin errors++; $display("FAIL reset_mid_next got %0d bad rows (first %0d) exp 0", m, bad_row); end
  endtask

  task automatic test_random();
    int hc, lh, wt, md, tl, m;
    logic exp_err;
    exp_err = 1'b0;
    for (int k = 0; k < 8; k++) begin
      hc = ($urandom_range(0, 3) == 0) ? $urandom_range(320, 511) : $urandom_range(0, 319);
      lh = $urandom_range(0, 255); wt = $urandom_range(0, 1);
      md = $urandom_range(0, 15);  tl = $urandom_range(0, 1);
      send_desc(hc, lh, wt, md, tl);
      if (hc >= 320) begin
        exp_err = 1'b1;
        checks++; if (ray_valid_out !== 1'b0 || col_error_out !== 1'b1) begin
          errors++; $display("FAIL rand_invalid hc %0d got valid %b err %b exp 0 1", hc, ray_valid_out, col_error_out); end
      end else begin
        collect(2, 180);
        m = col_mism(hc, lh, wt, md, tl);
        checks++; if (m !== 0 || stall_viol !== 0) begin
          errors++; $display("FAIL rand_column hc %0d lh %0d md %0d got %0d bad rows %0d stalls exp 0", hc, lh, md, m, stall_viol); end
        checks++; if (ray_valid_out !== 1'b0 || col_error_out !== exp_err) begin
          errors++; $display("FAIL rand_end got valid %b err %b exp 0 %b", ray_valid_out, col_error_out, exp_err); end
      end
    end
  endtask

  initial begin
    @(negedge pixel_clk_in);
    test_reset();
    test_basic();
    test_shade_clamp();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
